// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   localparam int unsigned PcIncr = 4;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StHold
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch or sequential step.
module fetch_unit_next_pc_calc
   import fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [DATA_W-1:0] instr,
   input  logic              jump,
   input  logic              pcsrc,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jmp_tgt;
   logic              unused_instr;

   assign pc4     = pc + ADDR_W'(PcIncr);
   assign br_off  = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
   assign jmp_tgt = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};

   // Opcode bits only matter to the controller, which already decided jump/pcsrc.
   assign unused_instr = ^instr[DATA_W-1:26];

   always_comb begin
      next_pc = pc4;
      if (jump) begin
         next_pc = jmp_tgt;
      end else if (pcsrc) begin
         next_pc = pc4 + br_off;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack FSM and valid/ready hand-off to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump,
   input  logic              pcsrc,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       retired
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] instr_q;
   logic              valid_q;
   logic              req_q;
   logic [31:0]       retired_q;
   logic [ADDR_W-1:0] next_pc;

   fetch_unit_next_pc_calc #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_next_pc_calc (
      .pc      (pc_q),
      .instr   (instr_q),
      .jump    (jump),
      .pcsrc   (pcsrc),
      .next_pc (next_pc)
   );

   // req_q and valid_q are updated alongside the state so neither output sees an input path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q <= StFetch;
               req_q   <= 1'b1;
            end
            StFetch: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= StHold;
               end
            end
            StHold: begin
               if (instr_ready) begin
                  pc_q      <= next_pc;
                  retired_q <= retired_q + 32'd1;
                  valid_q   <= 1'b0;
                  req_q     <= 1'b1;
                  state_q   <= StFetch;
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, branch/jump targets, stalls, reset and PC wrap.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic        pcsrc;
   logic [31:0] pc;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .funct       (funct),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump        (jump),
      .pcsrc       (pcsrc),
      .pc          (pc),
      .retired     (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // From a FETCH-cycle negedge: ack the word now, land on the HOLD-cycle negedge.
   task automatic deliver(input string tag, input logic [31:0] word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack = 1'b0;
      check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check_eq({tag, "_instr"}, instr, word);
      check_eq({tag, "_hreq"}, 32'(imem_req), 32'd0);
   endtask

   // From a HOLD-cycle negedge: handshake, land on the next FETCH-cycle negedge.
   task automatic accept(input string tag, input logic j, input logic b,
                         input logic [31:0] exp_pc, input logic [31:0] exp_ret);
      instr_ready = 1'b1;
      jump        = j;
      pcsrc       = b;
      tick();
      instr_ready = 1'b0;
      jump        = 1'b0;
      pcsrc       = 1'b0;
      check_eq({tag, "_addr"}, imem_addr, exp_pc);
      check_eq({tag, "_pc"}, pc, exp_pc);
      check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
      check_eq({tag, "_fvalid"}, 32'(instr_valid), 32'd0);
      check_eq({tag, "_retired"}, retired, exp_ret);
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = 32'h1234_5678;
      instr_ready = 1'b0;
      jump        = 1'b0;
      pcsrc       = 1'b0;
      tick();
      tick();
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_instr", instr, 32'h0);
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_retired", retired, 32'h0);

      // Release; the ack still high through the IDLE cycle must not be captured.
      rst_n = 1'b1;
      #1;
      check_eq("idle_req", 32'(imem_req), 32'd0);
      tick();

      // ack and ready tied high: 0x0, 0x4, 0x8 fetched back to back.
      instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("strm_addr", imem_addr, 32'(4 * i));
         check_eq("strm_req", 32'(imem_req), 32'd1);
         check_eq("strm_fvalid", 32'(instr_valid), 32'd0);
         check_eq("strm_retired", retired, 32'(i));
         imem_rdata = {OpLw, 26'(i)};
         tick();
         check_eq("strm_valid", 32'(instr_valid), 32'd1);
         check_eq("strm_instr", instr, {OpLw, 26'(i)});
         check_eq("strm_hreq", 32'(imem_req), 32'd0);
         imem_rdata = 32'hDEAD_0000;
         tick();
      end
      check_eq("strm_end_addr", imem_addr, 32'h0000_000C);
      check_eq("strm_end_retired", retired, 32'd3);
      imem_ack    = 1'b0;
      instr_ready = 1'b0;

      // R-type slices, then BEQ offset -1 at 0x10 taken and not taken.
      deliver("rtype", {OpRtype, 20'h0, 6'h20});
      check_eq("rtype_op", 32'(opcode), 32'(OpRtype));
      check_eq("rtype_funct", 32'(funct), 32'h20);
      accept("seq_10", 1'b0, 1'b0, 32'h0000_0010, 32'd4);
      deliver("beq_t", 32'h1000_FFFF);
      check_eq("beq_op", 32'(opcode), 32'(OpBeq));
      check_eq("beq_funct", 32'(funct), 32'h3F);
      accept("beq_taken", 1'b0, 1'b1, 32'h0000_0010, 32'd5);
      deliver("beq_n", 32'h1000_FFFF);
      accept("beq_not", 1'b0, 1'b0, 32'h0000_0014, 32'd6);

      // J at 0x14 to 0x20, then J at 0x20 stalled before the handshake.
      deliver("j20", 32'h0800_0008);
      check_eq("j_op", 32'(opcode), 32'(OpJ));
      accept("j_to_20", 1'b1, 1'b0, 32'h0000_0020, 32'd7);
      deliver("j100", 32'h0800_0040);
      for (int k = 0; k < 10; k++) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         jump       = k[0];
         pcsrc      = ~k[0];
         tick();
         check_eq("stall_instr", instr, 32'h0800_0040);
         check_eq("stall_valid", 32'(instr_valid), 32'd1);
         check_eq("stall_req", 32'(imem_req), 32'd0);
         check_eq("stall_pc", pc, 32'h0000_0020);
         check_eq("stall_retired", retired, 32'd7);
      end
      imem_ack = 1'b0;
      jump     = 1'b0;
      pcsrc    = 1'b0;
      accept("j_prio", 1'b1, 1'b1, 32'h0000_0100, 32'd8);

      // Branch back to 0xFFFFFFFC, then a sequential step wraps to 0.
      deliver("br_top", 32'h1000_FFBE);
      accept("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd9);
      deliver("sw_top", {OpSw, 26'h1});
      accept("wrap", 1'b0, 1'b0, 32'h0000_0000, 32'd10);
      deliver("sw_0", {OpSw, 26'h2});
      accept("seq_4", 1'b0, 1'b0, 32'h0000_0004, 32'd11);

      // Reset in the middle of a pending fetch.
      tick();
      check_eq("pend_addr", imem_addr, 32'h0000_0004);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_req", 32'(imem_req), 32'd0);
      check_eq("arst_valid", 32'(instr_valid), 32'd0);
      check_eq("arst_instr", instr, 32'h0);
      check_eq("arst_pc", pc, 32'h0);
      check_eq("arst_retired", retired, 32'h0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("rel_req", 32'(imem_req), 32'd0);
      tick();

      // Memory ack arrives in the fifth FETCH cycle; request must stay put.
      for (int k = 0; k < 5; k++) begin
         check_eq("wait_req", 32'(imem_req), 32'd1);
         check_eq("wait_addr", imem_addr, 32'h0);
         check_eq("wait_valid", 32'(instr_valid), 32'd0);
         check_eq("wait_instr", instr, 32'h0);
         imem_ack   = (k == 4);
         imem_rdata = 32'h8C00_0010;
         tick();
      end
      imem_ack = 1'b0;
      check_eq("late_valid", 32'(instr_valid), 32'd1);
      check_eq("late_instr", instr, 32'h8C00_0010);
      accept("after_rst", 1'b0, 1'b0, 32'h0000_0004, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
